// File: rtl/ram_mmio.sv
// Purpose : single-port data memory for the MIPS data side, with byte-enabled writes,
//           registered reads and NUM_PORTS memory-mapped output ports mirrored from the
//           low bits of their words. The memory is cleared by a sequential sweep.
// Latency : writes commit on the accept edge. Read data and rvalid appear one cycle
//           after accept. Back-to-back accepts run at one access per cycle.
// Backpr. : ready=0 while the clear sweep runs (busy=1) and in the cycle a clr pulse is
//           seen. The master holds req until ready. clr always wins over req.
// Ports   : clk, rst (async active-low), req/we/addr/wdata/be access request,
//           clr clear pulse, ready/busy status, rdata/rvalid read return,
//           port_out = NUM_PORTS fields of PORT_W bits, port i at [i*PORT_W +: PORT_W].
module ram_mmio #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 11,
    parameter int NUM_PORTS      = 1,
    parameter int PORT_W         = 8,
    parameter int PORT_BASE      = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           addr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W/8-1:0]         be,
    input  logic                        clr,
    output logic                        ready,
    output logic                        busy,
    output logic [DATA_W-1:0]           rdata,
    output logic                        rvalid,
    output logic [NUM_PORTS*PORT_W-1:0] port_out
);

    localparam int NBYTES = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_t                           state;
    state_t                           state_nx;
    logic [ADDR_W-1:0]                clr_ptr;
    logic [DATA_W-1:0]                mem [DEPTH];
    logic [NUM_PORTS-1:0][PORT_W-1:0] port_q;

    logic acc;
    logic wr_acc;
    logic rd_acc;
    logic start_clr;

    // Low PORT_W bits of the byte-merged word: bytes without an enable keep the
    // previous port value, which equals the stored memory bits for that port.
    function automatic logic [PORT_W-1:0] merge_port(
        input logic [PORT_W-1:0] old_val,
        input logic [PORT_W-1:0] new_val,
        input logic [NBYTES-1:0] ben
    );
        logic [PORT_W-1:0] r;
        r = old_val;
        for (int j = 0; j < PORT_W; j++) begin
            if (ben[j/8]) begin
                r[j] = new_val[j];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RST_STATE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ready     = 1'b0;
        busy      = 1'b0;
        start_clr = 1'b0;
        case (state)
            ST_CLEAR: begin
                busy = 1'b1;
                // The last word of the sweep is written this cycle.
                if (&clr_ptr) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready = !clr;
                if (clr) begin
                    start_clr = 1'b1;
                    state_nx  = ST_CLEAR;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign acc    = req & ready;
    assign wr_acc = acc & we;
    assign rd_acc = acc & ~we;

    // Sweep pointer. It wraps to zero on its own after DEPTH-1, so it is
    // already zero whenever the FSM sits in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_ptr <= '0;
        end else if (start_clr) begin
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + ADDR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Storage: no reset on the array so it maps onto block RAM.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Registered read port. rdata holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= mem[addr];
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory-mapped output ports
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_q <= '0;
        end else if (start_clr) begin
            port_q <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (addr == ADDR_W'(PORT_BASE + i)) begin
                    port_q[i] <= merge_port(port_q[i], wdata[PORT_W-1:0], be);
                end
            end
        end
    end

    assign port_out = port_q;

endmodule
